or_gate_arbiter: RTL and testbench
==================================

# or_gate_arbiter

Round-robin arbiter that shares one WD-bit `or_gate` datapath instance among NREQ requesters. Each requester presents an operand pair over a valid/ready handshake. The arbiter grants one requester per cycle and drives the shared `or_gate` (`.cin`, operand → `.out`, `.fout`). It registers the result with the winner's index into a single-entry response stage with its own valid/ready handshake. It sits between the requesting control blocks and the single `or_gate` instance in the datapath.

## Interface
- `WD`, 4: operand/result width; legal 1..32.
- `NREQ`, 4: number of requesters; legal 2..8.
- `IDW`, clog2(NREQ), min 1: width of `rsp_id`.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input NREQ: bit i = requester i has an operation pending.
- `req_ready` output NREQ: bit i = requester i accepted this cycle; one-hot or zero.
- `req_a` input NREQ*WD: operand A, requester i at bits [i*WD +: WD].
- `req_cin` input NREQ*WD: operand CIN, same packing.
- `rsp_valid` output 1: response register holds a result.
- `rsp_ready` input 1: consumer takes the response this cycle.
- `rsp_id` output IDW: index of the requester that produced the response.
- `rsp_out` output WD: `req_a | req_cin` of the granted requester (`or_gate.out`).
- `rsp_any` output 1: reduction OR of `rsp_out` (`or_gate.fout` nonzero).

## Operation
- FSM states:
  - EMPTY: response register invalid.
  - FULL: response register valid.
- Grant enable: `en = |req_valid && (EMPTY || (FULL && rsp_ready))`.
- Winner selection: first set `req_valid` bit searching from `ptr` upward, wrapping modulo NREQ.
- `req_ready[winner] = en`; all other ready bits are 0.
- `req_ready` is combinational from `req_valid`. Requesters must not derive valid from ready.
- Requesters hold `req_valid`, `req_a` and `req_cin` stable until accepted.
- On acceptance:
  - The shared `or_gate` result for the winner is captured into `rsp_out`/`rsp_any`.
  - The winner index is captured into `rsp_id`.
  - `ptr` becomes (winner+1) mod NREQ.
  - The FSM goes to FULL.
- FULL with `rsp_ready` and no acceptance: go to EMPTY, `rsp_valid` falls.
- FULL with `rsp_ready` and acceptance in the same cycle: stay FULL and load the new result (back-to-back, one result per cycle).
- FULL without `rsp_ready`:
  - `req_ready` is all zero.
  - `rsp_*` are held bit-stable.
  - `ptr` is unchanged.
- Fairness: a requester whose valid stays high is accepted within NREQ acceptances.
- `ptr` advances only on acceptance, never on idle cycles.
- Reset values:
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_out` = 0, `rsp_any` = 0.
  - `ptr` = 0 (requester 0 highest priority); state EMPTY.
  - `req_ready` = 0 while `rst` is high.
- Reset mid-operation discards any held response; no acceptance occurs in a reset cycle.

## Timing
- Latency: acceptance at edge N → `rsp_valid`/data visible after edge N, consumable in cycle N+1.
- Throughput: 1 op/cycle when `rsp_ready` is held high.
- Simultaneous `rsp_ready` and new request in FULL: the drain and the load happen on the same edge, with no bubble.
- `rst` overrides all same-cycle handshakes.
- Combinational paths:
  - `req_valid`/`rsp_ready` → `req_ready`: the only comb paths.
  - `req_a`/`req_cin` → `rsp_out`: registered only.

## Test plan
- Reset then single request: `req_valid=0001`, a=4'b0101, cin=4'b0010, rsp_ready=1 → `req_ready=0001` in cycle 0; next cycle `rsp_valid=1`, `rsp_id=0`, `rsp_out=4'b0111`, `rsp_any=1`.
- All four valid continuously, rsp_ready=1 → grant order 0,1,2,3,0,1…, one response per cycle, `rsp_id` sequence matches.
- Backpressure: two requesters valid, rsp_ready=0 for 5 cycles after the first accept → `req_ready=0`, `rsp_*` stable; on rsp_ready=1 the next grant goes to the other requester, with the same-edge reload.
- Zero result: a=0, cin=0 → `rsp_out=0`, `rsp_any=0`.
- Wrap-around: last grant requester 3 (`ptr=0`), then `req_valid=1001` → grant 0, then 3.
- Reset mid-operation: rst in FULL with rsp_ready=0 → next cycle `rsp_valid=0`, `ptr=0`; `req_valid=1111` → grant 0.

Source files
------------

// File: rtl/or_gate_arbiter.sv
// Round-robin arbiter sharing a single or_gate datapath among NREQ requesters.
// Each cycle at most one requester is accepted; its a|cin result and its index
// are captured into a one-entry response register with its own handshake.
//
// Handshake rules (both sides): a transfer happens on a rising edge where
// valid and ready are both high. Requesters hold valid and operands stable
// until accepted and must not derive valid from ready. req_ready is
// combinational from req_valid/rsp_ready/rst; the response side is registered.

// Shared bitwise-OR datapath element.
module or_gate #(
  parameter int WD = 4
) (
  input  logic [WD-1:0] a,
  input  logic [WD-1:0] cin,
  output logic [WD-1:0] out,
  output logic          fout
);
  assign out  = a | cin;
  assign fout = |out;
endmodule

module or_gate_arbiter #(
  parameter int WD   = 4,
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*WD-1:0] req_a,
  input  logic [NREQ*WD-1:0] req_cin,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [WD-1:0]     rsp_out,
  output logic              rsp_any,
  output logic              o_dbg_state,
  output logic [IDW-1:0]    o_dbg_ptr
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic [WD-1:0]   r_out;
  logic            r_any;

  logic [NREQ-1:0] w_rot;
  logic            w_found;
  logic [IDW-1:0]  w_winner;
  logic [IDW-1:0]  w_ptr_nxt;
  logic            w_en;
  logic [WD-1:0]   w_sel_a;
  logic [WD-1:0]   w_sel_cin;
  logic [WD-1:0]   w_or_out;
  logic            w_or_fout;

  // Rotate requests so that the pointer position becomes bit 0; the first
  // set bit of the rotated vector is the winner offset from the pointer.
  always_comb begin : p_pick
    logic [IDW:0] v_sum;
    v_sum    = '0;
    w_found  = 1'b0;
    w_winner = '0;
    w_rot    = NREQ'({req_valid, req_valid} >> r_ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        v_sum   = {1'b0, r_ptr} + (IDW+1)'(k);
        if (v_sum >= (IDW+1)'(NREQ)) begin
          v_sum = v_sum - (IDW+1)'(NREQ);
        end
        w_winner = v_sum[IDW-1:0];
      end
    end
  end

  // Accept when something is pending and the response slot is free or draining.
  assign w_en = !rst && w_found && ((r_state == S_EMPTY) || rsp_ready);

  // Pointer moves just past the winner, wrapping at NREQ.
  always_comb begin
    w_ptr_nxt = '0;
    if (w_winner != IDW'(NREQ - 1)) begin
      w_ptr_nxt = w_winner + IDW'(1);
    end
  end

  // Operand mux feeding the shared or_gate, plus the one-hot ready.
  always_comb begin
    w_sel_a   = '0;
    w_sel_cin = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_winner == IDW'(i)) begin
        w_sel_a      = req_a[i*WD +: WD];
        w_sel_cin    = req_cin[i*WD +: WD];
        req_ready[i] = w_en;
      end
    end
  end

  or_gate #(.WD(WD)) u_or_gate (
    .a    (w_sel_a),
    .cin  (w_sel_cin),
    .out  (w_or_out),
    .fout (w_or_fout)
  );

  // Response-slot state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: an acceptance always fills the slot; a drain without a
  // same-edge acceptance empties it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_en) w_state_nxt = S_FULL;
      S_FULL: begin
        if (w_en) begin
          w_state_nxt = S_FULL;
        end else if (rsp_ready) begin
          w_state_nxt = S_EMPTY;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Response payload and pointer only change on an acceptance, so a stalled
  // response stays bit-stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_id  <= '0;
      r_out <= '0;
      r_any <= 1'b0;
    end else if (w_en) begin
      r_ptr <= w_ptr_nxt;
      r_id  <= w_winner;
      r_out <= w_or_out;
      r_any <= w_or_fout;
    end
  end

  assign rsp_valid   = (r_state == S_FULL);
  assign rsp_id      = r_id;
  assign rsp_out     = r_out;
  assign rsp_any     = r_any;
  assign o_dbg_state = r_state;
  assign o_dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_or_gate_arbiter.sv
// Bench for or_gate_arbiter: directed vector table, then randomized traffic
// checked against a queue-based reference model.
module tb_or_gate_arbiter;

  localparam int WD   = 4;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam logic [15:0] VA = 16'h8421;
  localparam logic [15:0] VC = 16'h0048;

  // clock / reset block
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*WD-1:0] req_a;
  logic [NREQ*WD-1:0] req_cin;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [WD-1:0]      rsp_out;
  logic               rsp_any;
  logic               dbg_state;
  logic [IDW-1:0]     dbg_ptr;

  or_gate_arbiter #(.WD(WD), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_cin     (req_cin),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_out     (rsp_out),
    .rsp_any     (rsp_any),
    .o_dbg_state (dbg_state),
    .o_dbg_ptr   (dbg_ptr)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // directed vectors: inputs, ready before the edge, response after the edge
  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [15:0] a;
    logic [15:0] c;
    logic        rr;
    logic [3:0]  e_rdy;
    logic        e_rv;
    logic        chk;
    logic [1:0]  e_id;
    logic [3:0]  e_out;
    logic        e_any;
  } vec_t;

  vec_t tbl[25];

  // scoreboard / reference model state
  logic [IDW+WD-1:0] exp_q[$];
  int          m_ptr;
  logic [3:0]  pend;
  logic [3:0]  op_a[NREQ];
  logic [3:0]  op_c[NREQ];
  int          waits[NREQ];
  logic        r_drv;
  logic        rr_drv;
  logic        m_en;
  logic [3:0]  erdy;
  int          win;
  logic [IDW+WD-1:0] head;

  // Lowest pending index at or above the pointer, else lowest pending overall.
  function automatic int pick(input logic [3:0] v, input int p);
    int best;
    best = -1;
    for (int i = 0; i < NREQ; i++) if (v[i] && i >= p && best < 0) best = i;
    for (int i = 0; i < NREQ; i++) if (v[i] && best < 0) best = i;
    return best;
  endfunction

  task automatic drive(input logic r, input logic [3:0] v, input logic [15:0] a,
                       input logic [15:0] c, input logic rr);
    rst       = r;
    req_valid = v;
    req_a     = a;
    req_cin   = c;
    rsp_ready = rr;
  endtask

  initial begin
    drive(1'b1, 4'h0, 16'h0, 16'h0, 1'b0);
    tbl[0]  = '{1'b1, 4'hf, VA, VC, 1'b0, 4'h0, 1'b0, 1'b1, 2'd0, 4'h0, 1'b0};
    tbl[1]  = '{1'b0, 4'h1, 16'h0005, 16'h0002, 1'b1, 4'h1, 1'b1, 1'b1, 2'd0, 4'h7, 1'b1};
    tbl[2]  = '{1'b0, 4'h2, 16'h0000, 16'h0000, 1'b1, 4'h2, 1'b1, 1'b1, 2'd1, 4'h0, 1'b0};
    tbl[3]  = '{1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
    tbl[4]  = '{1'b1, 4'h0, 16'h0000, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b1, 2'd0, 4'h0, 1'b0};
    tbl[5]  = '{1'b0, 4'hf, VA, VC, 1'b1, 4'h1, 1'b1, 1'b1, 2'd0, 4'h9, 1'b1};
    tbl[6]  = '{1'b0, 4'hf, VA, VC, 1'b1, 4'h2, 1'b1, 1'b1, 2'd1, 4'h6, 1'b1};
    tbl[7]  = '{1'b0, 4'hf, VA, VC, 1'b1, 4'h4, 1'b1, 1'b1, 2'd2, 4'h4, 1'b1};
    tbl[8]  = '{1'b0, 4'hf, VA, VC, 1'b1, 4'h8, 1'b1, 1'b1, 2'd3, 4'h8, 1'b1};
    tbl[9]  = '{1'b0, 4'h1, VA, VC, 1'b1, 4'h1, 1'b1, 1'b1, 2'd0, 4'h9, 1'b1};
    for (int i = 10; i < 15; i++)
      tbl[i] = '{1'b0, 4'h6, VA, VC, 1'b0, 4'h0, 1'b1, 1'b1, 2'd0, 4'h9, 1'b1};
    tbl[15] = '{1'b0, 4'h6, VA, VC, 1'b1, 4'h2, 1'b1, 1'b1, 2'd1, 4'h6, 1'b1};
    tbl[16] = '{1'b0, 4'h4, VA, VC, 1'b1, 4'h4, 1'b1, 1'b1, 2'd2, 4'h4, 1'b1};
    tbl[17] = '{1'b0, 4'h8, VA, VC, 1'b1, 4'h8, 1'b1, 1'b1, 2'd3, 4'h8, 1'b1};
    tbl[18] = '{1'b0, 4'h9, VA, VC, 1'b1, 4'h1, 1'b1, 1'b1, 2'd0, 4'h9, 1'b1};
    tbl[19] = '{1'b0, 4'h8, VA, VC, 1'b1, 4'h8, 1'b1, 1'b1, 2'd3, 4'h8, 1'b1};
    tbl[20] = '{1'b0, 4'h2, VA, VC, 1'b1, 4'h2, 1'b1, 1'b1, 2'd1, 4'h6, 1'b1};
    tbl[21] = '{1'b1, 4'h4, VA, VC, 1'b0, 4'h0, 1'b0, 1'b1, 2'd0, 4'h0, 1'b0};
    tbl[22] = '{1'b0, 4'hf, VA, VC, 1'b1, 4'h1, 1'b1, 1'b1, 2'd0, 4'h9, 1'b1};
    tbl[23] = '{1'b0, 4'h0, VA, VC, 1'b0, 4'h0, 1'b1, 1'b1, 2'd0, 4'h9, 1'b1};
    tbl[24] = '{1'b0, 4'h0, VA, VC, 1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};

    repeat (2) @(posedge clk);
    #1;

    // directed phase
    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].a, tbl[i].c, tbl[i].rr);
      #1;
      check($sformatf("v%0d_ready", i), 32'(req_ready), 32'(tbl[i].e_rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", i), 32'(rsp_valid), 32'(tbl[i].e_rv));
      if (tbl[i].chk) begin
        check($sformatf("v%0d_id", i),  32'(rsp_id),  32'(tbl[i].e_id));
        check($sformatf("v%0d_out", i), 32'(rsp_out), 32'(tbl[i].e_out));
        check($sformatf("v%0d_any", i), 32'(rsp_any), 32'(tbl[i].e_any));
      end
    end

    // randomized phase against the reference model
    pend  = 4'h0;
    m_ptr = 0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i]  = 4'h0;
      op_c[i]  = 4'h0;
      waits[i] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r_drv  = (cyc == 0) || ($urandom_range(0, 99) == 0);
      rr_drv = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          op_a[i] = 4'($urandom_range(0, 15));
          op_c[i] = 4'($urandom_range(0, 15));
        end
      end
      drive(r_drv, pend, {op_a[3], op_a[2], op_a[1], op_a[0]},
            {op_c[3], op_c[2], op_c[1], op_c[0]}, rr_drv);
      m_en = !r_drv && (pend != 4'h0) && (exp_q.size() == 0 || rr_drv);
      win  = pick(pend, m_ptr);
      erdy = m_en ? (4'b0001 << win) : 4'h0;
      #1;
      check("rnd_ready", 32'(req_ready), 32'(erdy));
      @(posedge clk);
      if (r_drv) begin
        exp_q.delete();
        m_ptr = 0;
        for (int i = 0; i < NREQ; i++) waits[i] = 0;
      end else begin
        if (exp_q.size() > 0 && rr_drv) void'(exp_q.pop_front());
        if (m_en) begin
          check("rnd_fair", 32'(waits[win] < NREQ), 32'd1);
          for (int i = 0; i < NREQ; i++) if (pend[i] && i != win) waits[i]++;
          waits[win] = 0;
          exp_q.push_back({2'(win), op_a[win] | op_c[win]});
          m_ptr = (win + 1) % NREQ;
          pend[win] = 1'b0;
        end
      end
      #1;
      check("rnd_valid", 32'(rsp_valid), 32'(exp_q.size() > 0));
      check("rnd_state", 32'(dbg_state), 32'(exp_q.size() > 0));
      check("rnd_ptr", 32'(dbg_ptr), 32'(m_ptr));
      if (exp_q.size() > 0) begin
        head = exp_q[0];
        check("rnd_id",  32'(rsp_id),  32'(head[WD +: IDW]));
        check("rnd_out", 32'(rsp_out), 32'(head[WD-1:0]));
        check("rnd_any", 32'(rsp_any), 32'(head[WD-1:0] != 4'h0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
